// File: rtl/packet_streamer_pkg.sv
// Shared types, character constants and the nibble-to-ASCII helper for the
// packet streamer and the command parser's reply path.
package packet_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        NIBBLE,
        CSUM_HI,
        CSUM_LO,
        EOL
    } state_t;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] EOL_CHAR   = 8'h0D;

    // Uppercase hex digit for a 4-bit value.
    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble < 4'd10) begin
            return ASCII_ZERO + {4'h0, nibble};
        end
        return ASCII_A + {4'h0, nibble - 4'd10};
    endfunction

endpackage

// File: rtl/packet_streamer_if.sv
// Valid/ready byte stream between the packet streamer and the byte transmitter.
interface packet_streamer_if;

    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_byte, output tx_valid, input tx_ready);
    modport slave  (input tx_byte, input tx_valid, output tx_ready);

endinterface

// File: rtl/packet_streamer.sv
// Streams a latched packet as ASCII-hex characters, MSB nibble first, followed
// by a two-character additive checksum and a carriage return.
module packet_streamer
    import packet_streamer_pkg::*;
#(
    parameter int PACKET_SIZE = 256
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PACKET_SIZE-1:0] packet_data,
    input  logic                   packet_valid,
    output logic                   busy,
    packet_streamer_if.master      tx,
    output logic [7:0]             overrun_count
);

    localparam int NIBBLES     = PACKET_SIZE / 4;
    localparam int NIBBLE_BITS = $clog2(NIBBLES) + 1;

    state_t                 state;
    state_t                 state_next;
    logic [PACKET_SIZE-1:0] shift_reg;
    logic [NIBBLE_BITS-1:0] nibble_count;
    logic [7:0]             checksum;
    logic                   handshake;
    logic                   accept;
    logic                   overrun;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        busy        = (state != IDLE);
        tx.tx_valid = (state != IDLE);
        tx.tx_byte  = 8'h00;
        handshake   = (state != IDLE) && tx.tx_ready;
        // A new packet may start on the same cycle the terminator leaves.
        accept      = packet_valid && enable &&
                      ((state == IDLE) || ((state == EOL) && handshake));
        overrun     = packet_valid && enable && !accept;

        case (state)
            IDLE: begin
                if (accept) state_next = NIBBLE;
            end
            NIBBLE: begin
                tx.tx_byte = hex_ascii(shift_reg[PACKET_SIZE-1 -: 4]);
                if (handshake && (nibble_count == NIBBLE_BITS'(1))) begin
                    state_next = CSUM_HI;
                end
            end
            CSUM_HI: begin
                tx.tx_byte = hex_ascii(checksum[7:4]);
                if (handshake) state_next = CSUM_LO;
            end
            CSUM_LO: begin
                tx.tx_byte = hex_ascii(checksum[3:0]);
                if (handshake) state_next = EOL;
            end
            EOL: begin
                tx.tx_byte = EOL_CHAR;
                if (handshake) state_next = accept ? NIBBLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: the datapath is left out of reset; it is fully reloaded on every
    // acceptance and is never observed while the FSM sits in IDLE.
    always_ff @(posedge sysclk) begin
        if (accept) begin
            shift_reg    <= packet_data;
            checksum     <= 8'h00;
            nibble_count <= NIBBLE_BITS'(NIBBLES);
        end else if ((state == NIBBLE) && handshake) begin
            shift_reg    <= shift_reg << 4;
            checksum     <= checksum + tx.tx_byte;
            nibble_count <= nibble_count - NIBBLE_BITS'(1);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            overrun_count <= 8'h00;
        end else if (overrun && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'h01;
        end
    end

endmodule

// File: doc/packet_streamer.md
Name: packet_streamer

Overview:
- Downstream of the correlator top level: consumes the assembled correlator packet (header + payload snapshot taken each integration tick) and streams it as ASCII-hex bytes to the UART/SPI byte transmitter.
- Adds an 8-bit additive checksum and an end-of-line terminator, with a valid/ready byte handshake.
- Counts packets dropped because a previous packet was still streaming.

Parameters:
- PACKET_SIZE, 256, packet width in bits; must be a multiple of 4 and at least 4.
- NIBBLE_BITS, $clog2(PACKET_SIZE/4)+1, width of the internal nibble counter (derived; not overridden).

Ports:
- sysclk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, new packets are not accepted; a packet already in progress completes.
- packet_data  input  PACKET_SIZE  packet snapshot; sampled only on the acceptance cycle.
- packet_valid  input  1  one-cycle request to stream packet_data.
- busy  output  1  high from acceptance until the terminator byte is handshaken.
- tx_byte  output  8  current output character.
- tx_valid  output  1  tx_byte is valid.
- tx_ready  input  1  sink accepts tx_byte on any cycle where tx_valid && tx_ready.
- overrun_count  output  8  saturating count of dropped packet_valid pulses.

Behaviour:
- Reset (sysclk edge with reset=1):
  - busy=0, tx_valid=0, tx_byte=0x00, overrun_count=0, state=IDLE.
  - Any in-flight packet is discarded; outputs take these values on the next cycle.
- States: IDLE, NIBBLE, CSUM_HI, CSUM_LO, EOL.
- Acceptance: packet_valid && enable && (state==IDLE, or state==EOL with the terminator handshaken this cycle). On acceptance:
  - Latch packet_data into the shift register; clear checksum; nibble counter = PACKET_SIZE/4.
  - Next cycle: state=NIBBLE, busy=1, tx_valid=1, tx_byte = ASCII of packet_data[PACKET_SIZE-1 -: 4]. Latency is one cycle.
- ASCII encoding: 0-9 map to 0x30-0x39; A-F map to 0x41-0x46 (uppercase).
- Handshake:
  - tx_byte and tx_valid stay stable while tx_valid && !tx_ready.
  - Advance only on tx_valid && tx_ready. The next byte appears on the following cycle, so there are no bubbles when tx_ready is held high.
- NIBBLE:
  - On each handshake: checksum += tx_byte (mod 256); shift left by 4; decrement the counter.
  - After the last nibble is handshaken, go to CSUM_HI.
  - Nibbles are sent MSB first.
- CSUM_HI: send ASCII of checksum[7:4], where checksum is the 8-bit mod-256 sum of all nibble characters. The checksum characters are not added to the sum.
- CSUM_LO: send ASCII of checksum[3:0].
- EOL:
  - Send 0x0D.
  - On handshake: go to IDLE with busy=0 and tx_valid=0, unless a new packet is accepted that same cycle (back-to-back). In the back-to-back case busy stays 1 and the first character of the new packet follows immediately.
- Overrun: overrun_count increments by one, saturating at 255, on any packet_valid && enable that is not accepted (i.e. the block is busy). It does not increment when enable=0.
- enable falling mid-packet has no effect on the packet in progress.
- packet_data changes after acceptance have no effect on the packet in progress.
- Total bytes per packet = PACKET_SIZE/4 + 3.

Decomposition:
- Shared package:
  - State enum (IDLE, NIBBLE, CSUM_HI, CSUM_LO, EOL).
  - Constants ASCII_ZERO=0x30, ASCII_A=0x41, EOL_CHAR=0x0D.
  - Function hex_ascii(nibble) -> 8-bit character, reused by the command parser's reply path.
- No sub-module beyond the function; the FSM, shift register, counter and checksum accumulator live in one module.

Test Plan:
- PACKET_SIZE=16, packet_data=0x1A2F, tx_ready held 1:
  - Bytes 0x31, 0x41, 0x32, 0x46, 0x45, 0x41, 0x0D on consecutive cycles (checksum 0xEA).
  - busy high exactly 7 cycles.
- Same packet, tx_ready toggling 1/0 pseudo-randomly: identical byte sequence; tx_byte stable throughout every stall.
- Second packet_valid (0xFFFF) mid-stream: first packet unaffected; overrun_count=1.
- 300 such overlapping pulses: overrun_count saturates at 255.
- packet_valid=0x0000 on the cycle the 0x0D is handshaken:
  - Next cycle tx_byte=0x30, busy stays 1, overrun_count unchanged.
  - Sequence 30 30 30 30 43 30 0D (checksum 0xC0).
- reset asserted during the third nibble:
  - Next cycle tx_valid=0, busy=0, overrun_count=0.
  - A following packet 0x1A2F streams correctly from its first character.
- enable=0 with packet_valid: no bytes, busy stays 0, overrun_count unchanged.
